pipe_run_monitor: RTL and testbench

Synthesizable run-control and trace monitor for the pipelined RV32 core. It sits beside the CPU inside the top-level computer wrapper. It counts cycles, stops the run when a parametrised halt PC is reached or a cycle budget is exhausted, and keeps a circular trace of the most recent register writebacks. After the stop it sequences a full register-file dump out through a valid/ready stream.

---
 rtl/pipe_run_monitor_if.sv | 9 +
 rtl/pipe_run_monitor.sv | 102 ++++++++++
 tb/tb_pipe_run_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_run_monitor_if.sv
// pipe_run_monitor_if: register-dump valid/ready stream from the run monitor to its consumer
interface pipe_run_monitor_if #(parameter int XLEN = 32);
  logic            dump_valid;
  logic            dump_ready;
  logic [4:0]      dump_idx;
  logic [XLEN-1:0] dump_data;
  modport master (output dump_valid, dump_idx, dump_data, input dump_ready);
  modport slave (input dump_valid, dump_idx, dump_data, output dump_ready);
endinterface

// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor: run control, writeback trace and register dump; define TRACE_PC_EN to store writeback PCs in the trace
module pipe_run_monitor #(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] HALT_PC    = 32'h0000_0100,
  parameter int             MAX_CYCLES  = 1000,
  parameter int             TRACE_DEPTH = 16,
  parameter int             NREGS       = 32,
  localparam int            TW          = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] wb_pc,
  output logic [4:0]      reg_sel,
  input  logic [XLEN-1:0] reg_data,
  pipe_run_monitor_if.master dump,
  output logic [1:0]      run_state,
  output logic            halted,
  output logic            timeout,
  output logic [31:0]     cycle_cnt,
  input  logic [TW-1:0]   trace_rd_idx,
  output logic            trace_rd_hit,
  output logic [4:0]      trace_rd_rd,
  output logic [XLEN-1:0] trace_rd_data,
  output logic [XLEN-1:0] trace_rd_pc,
  output logic [TW:0]     trace_count
);
  typedef enum logic [1:0] {RUN = 2'd0, DUMP = 2'd1, DONE = 2'd2} state_t;
  localparam logic [TW:0] FULL = (TW+1)'(TRACE_DEPTH);
  state_t state, state_n;
  logic [4:0] idx;
  logic [TW-1:0] wr_ptr, rd_addr;
  logic halt_hit, to_hit, wr_en, beat, last, rd_hit;
  logic [4:0] tr_rd [TRACE_DEPTH];
  logic [XLEN-1:0] tr_data [TRACE_DEPTH];
  // halt has priority over an expiring budget in the same cycle
  assign halt_hit = state == RUN && pc_in == HALT_PC;
  assign to_hit = state == RUN && !halt_hit && cycle_cnt == 32'(MAX_CYCLES - 1);
  assign beat = dump.dump_valid && dump.dump_ready;
  assign last = idx == 5'(NREGS - 1);
  assign wr_en = state == RUN && wb_valid && wb_rd != 5'd0;
  assign rd_addr = wr_ptr - TW'(1) - trace_rd_idx;
  assign rd_hit = {1'b0, trace_rd_idx} < trace_count;
  always_comb begin
    state_n = state;
    state_n = (halt_hit || to_hit) ? DUMP : (beat && last) ? DONE : state;
  end
  assign run_state = state;
  assign reg_sel = idx;
  assign dump.dump_valid = state == DUMP;
  assign dump.dump_idx = idx;
  assign dump.dump_data = idx == 5'd0 ? '0 : reg_data;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RUN;
      cycle_cnt <= '0;
      halted <= 1'b0;
      timeout <= 1'b0;
      idx <= '0;
      wr_ptr <= '0;
      trace_count <= '0;
      trace_rd_hit <= 1'b0;
      trace_rd_rd <= '0;
      trace_rd_data <= '0;
    end else begin
      state <= state_n;
      if (state == RUN) cycle_cnt <= cycle_cnt + 32'd1;
      if (halt_hit) halted <= 1'b1;
      if (to_hit) timeout <= 1'b1;
      if (beat && !last) idx <= idx + 5'd1;
      if (wr_en) wr_ptr <= wr_ptr + TW'(1);
      if (wr_en && trace_count != FULL) trace_count <= trace_count + 1'b1;
      trace_rd_hit <= rd_hit;
      trace_rd_rd <= rd_hit ? tr_rd[rd_addr] : '0;
      trace_rd_data <= rd_hit ? tr_data[rd_addr] : '0;
    end
  end
  // trace storage is not cleared; trace_count masks stale entries
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tr_rd[wr_ptr] <= wb_rd;
      tr_data[wr_ptr] <= wb_data;
    end
  end
`ifdef TRACE_PC_EN
  logic [XLEN-1:0] tr_pc [TRACE_DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) tr_pc[wr_ptr] <= wb_pc;
  end
  always_ff @(posedge clk) begin
    if (!rstn) trace_rd_pc <= '0;
    else trace_rd_pc <= rd_hit ? tr_pc[rd_addr] : '0;
  end
`else
  logic pc_unused;
  assign pc_unused = ^wb_pc;
  assign trace_rd_pc = '0;
`endif
endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb_pipe_run_monitor: directed checks of halt, timeout, dump stream, trace and reset
module tb_pipe_run_monitor;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [31:0] pc_in = '0;
  logic wb_valid = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] wb_pc = '0;
  logic [3:0] trace_rd_idx = '0;
  logic dump_ready = 1'b0;
  logic [4:0] a_sel, t_sel, a_rrd, t_rrd;
  logic [31:0] a_rdata, t_rdata, a_cnt, t_cnt, a_tdata, t_tdata, a_tpc, t_tpc;
  logic [1:0] a_state, t_state;
  logic a_halted, t_halted, a_to, t_to, a_hit, t_hit;
  logic [4:0] a_tcount, t_tcount;
  int total = 0;
  int bad = 0;
  pipe_run_monitor_if da ();
  pipe_run_monitor_if dt ();
  always #5 clk = ~clk;
  assign a_rdata = 32'hA000_0000 + {27'b0, a_sel};
  assign t_rdata = 32'hA000_0000 + {27'b0, t_sel};
  assign da.dump_ready = dump_ready;
  assign dt.dump_ready = dump_ready;
  pipe_run_monitor #(.HALT_PC(32'h100), .MAX_CYCLES(1000)) u_a (
    .clk(clk), .rstn(rstn), .pc_in(pc_in), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .reg_sel(a_sel), .reg_data(a_rdata), .dump(da),
    .run_state(a_state), .halted(a_halted), .timeout(a_to), .cycle_cnt(a_cnt),
    .trace_rd_idx(trace_rd_idx), .trace_rd_hit(a_hit), .trace_rd_rd(a_rrd),
    .trace_rd_data(a_tdata), .trace_rd_pc(a_tpc), .trace_count(a_tcount));
  pipe_run_monitor #(.HALT_PC(32'h100), .MAX_CYCLES(20)) u_t (
    .clk(clk), .rstn(rstn), .pc_in(pc_in), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .reg_sel(t_sel), .reg_data(t_rdata), .dump(dt),
    .run_state(t_state), .halted(t_halted), .timeout(t_to), .cycle_cnt(t_cnt),
    .trace_rd_idx(trace_rd_idx), .trace_rd_hit(t_hit), .trace_rd_rd(t_rrd),
    .trace_rd_data(t_tdata), .trace_rd_pc(t_tpc), .trace_count(t_tcount));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask
  initial begin
    int e, k;
    logic [31:0] exp_d;
    do_reset();
    chk("rst_state", a_state, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_halted", a_halted, 0);
    chk("rst_timeout", a_to, 0);
    chk("rst_dump_valid", da.dump_valid, 0);
    chk("rst_dump_idx", da.dump_idx, 0);
    chk("rst_reg_sel", a_sel, 0);
    chk("rst_tcount", a_tcount, 0);
    chk("rst_hit", a_hit, 0);
    chk("rst_tpc", a_tpc, 0);
    tick();
    chk("empty_hit", a_hit, 0);
    chk("empty_data", a_tdata, 0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    tick();
    wb_valid = 1'b0;
    chk("rbw_hit", a_hit, 0);
    chk("one_count", a_tcount, 1);
    tick();
    chk("one_hit", a_hit, 1);
    chk("one_data", a_tdata, 32'h33);
    chk("one_rd", a_rrd, 3);
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'(i);
      tick();
    end
    wb_valid = 1'b0;
    trace_rd_idx = 4'd0;
    tick();
    chk("wrap_count", a_tcount, 16);
    chk("wrap_idx0_hit", a_hit, 1);
    chk("wrap_idx0_data", a_tdata, 20);
    chk("wrap_idx0_rd", a_rrd, 20);
    trace_rd_idx = 4'd15;
    tick();
    chk("wrap_idx15_data", a_tdata, 5);
    chk("wrap_idx15_rd", a_rrd, 5);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd99; trace_rd_idx = 4'd0;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("x0_count", a_tcount, 16);
    chk("x0_idx0_data", a_tdata, 20);
    do_reset();
    k = 0;
    while (a_state == 2'd0 && k < 200) begin
      pc_in = 32'(4 * k);
      tick();
      k++;
    end
    chk("halt_state", a_state, 1);
    chk("halt_flag", a_halted, 1);
    chk("halt_no_to", a_to, 0);
    chk("halt_cnt", a_cnt, 32'h41);
    chk("to_state", t_state, 1);
    chk("to_flag", t_to, 1);
    chk("to_no_halt", t_halted, 0);
    chk("to_cnt", t_cnt, 20);
    e = 0;
    k = 0;
    while (e < 32 && k < 200) begin
      exp_d = e == 0 ? 32'h0 : 32'hA000_0000 + 32'(e);
      chk("dump_valid", da.dump_valid, 1);
      chk("dump_idx", da.dump_idx, e);
      chk("dump_data", da.dump_data, exp_d);
      dump_ready = (k % 2) == 0;
      tick();
      if (dump_ready) e++;
      k++;
    end
    dump_ready = 1'b0;
    chk("dump_beats", e, 32);
    chk("done_state", a_state, 2);
    chk("done_valid", da.dump_valid, 0);
    pc_in = 32'h0;
    tick();
    chk("done_cnt_frozen", a_cnt, 32'h41);
    chk("done_halted", a_halted, 1);
    do_reset();
    k = 0;
    while (t_state == 2'd0 && k < 100) begin
      pc_in = 32'hB4 + 32'(4 * k);
      tick();
      k++;
    end
    chk("both_state", t_state, 1);
    chk("both_halted", t_halted, 1);
    chk("both_no_to", t_to, 0);
    chk("both_cnt", t_cnt, 20);
    do_reset();
    pc_in = 32'h0;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
    tick();
    wb_rd = 5'd2;
    tick();
    wb_valid = 1'b0;
    pc_in = 32'h100;
    tick();
    pc_in = 32'h0;
    chk("mid_count", a_tcount, 2);
    dump_ready = 1'b1;
    k = 0;
    while (da.dump_idx != 5'd10 && k < 50) begin
      tick();
      k++;
    end
    chk("mid_idx", da.dump_idx, 10);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    dump_ready = 1'b0;
    chk("mid_rst_state", a_state, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_valid", da.dump_valid, 0);
    chk("mid_rst_idx", da.dump_idx, 0);
    chk("mid_rst_count", a_tcount, 0);
    chk("mid_rst_halted", a_halted, 0);
    chk("mid_rst_timeout", a_to, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
